// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Hazard/stall controller for the 5-stage pipeline: load-use
//            interlock, memory handshake wait with timeout, branch flush.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 255,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic [REG_ADDR_W-1:0] ex_wb_addr,
   input  logic                  ex_mem_read,
   input  logic                  mem_req,
   input  logic                  mem_ack,
   input  logic                  branch_taken,
   output logic                  stall_if,
   output logic                  stall_id,
   output logic                  bubble_ex,
   output logic                  stall_ex,
   output logic                  stall_mem,
   output logic                  flush_id,
   output logic                  mem_timeout,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_t;

   state_t           r_state;
   logic [15:0]      r_wait_cnt;
   logic             r_mem_timeout;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_lu;
   logic w_mw;

   assign w_lu = ex_mem_read && (ex_wb_addr != '0) &&
                 ((id_use_rs && (id_rs == ex_wb_addr)) ||
                  (id_use_rt && (id_rt == ex_wb_addr)));

   // Once timed out the wait is masked so the pipeline can drain.
   assign w_mw = mem_req && !mem_ack && !r_mem_timeout;

   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      flush_id  = 1'b0;
      if (!rst) begin
         if (w_mw) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
         end else if (branch_taken) begin
            flush_id  = 1'b1;
         end else if (w_lu) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= 16'd0;
         r_mem_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_mw) begin
                  if (c_TIMEOUT == 16'd1) begin
                     r_state       <= ST_ERR;
                     r_mem_timeout <= 1'b1;
                  end else begin
                     r_state <= ST_MEM_WAIT;
                  end
                  r_wait_cnt <= 16'd1;
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ack || !mem_req) begin
                  r_state    <= ST_RUN;
                  r_wait_cnt <= 16'd0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
                  if (r_wait_cnt + 16'd1 == c_TIMEOUT) begin
                     r_state       <= ST_ERR;
                     r_mem_timeout <= 1'b1;
                  end
               end
            end
            ST_ERR: begin
               r_state <= ST_ERR;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   // Performance counters saturate at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_if && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (flush_id && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign mem_timeout = r_mem_timeout;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed vector table plus multi-cycle sequences for pipeline_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipeline_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_wb_addr;
   logic       id_use_rs, id_use_rt, ex_mem_read;
   logic       mem_req, mem_ack, branch_taken;
   logic       stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_id;
   logic       mem_timeout;
   logic [31:0] stall_cnt, flush_cnt;

   logic       s_stall_if, s_stall_id, s_bubble_ex, s_stall_ex, s_stall_mem, s_flush_id;
   logic       s_mem_timeout;
   logic [1:0] s_stall_cnt, s_flush_cnt;

   int total = 0;
   int bad   = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   pipeline_ctrl #(.REG_ADDR_W(5), .TIMEOUT(4), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_wb_addr(ex_wb_addr), .ex_mem_read(ex_mem_read),
      .mem_req(mem_req), .mem_ack(mem_ack), .branch_taken(branch_taken),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
      .stall_ex(stall_ex), .stall_mem(stall_mem), .flush_id(flush_id),
      .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter copy sharing the stimulus, to observe saturation.
   pipeline_ctrl #(.REG_ADDR_W(5), .TIMEOUT(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_wb_addr(ex_wb_addr), .ex_mem_read(ex_mem_read),
      .mem_req(mem_req), .mem_ack(mem_ack), .branch_taken(branch_taken),
      .stall_if(s_stall_if), .stall_id(s_stall_id), .bubble_ex(s_bubble_ex),
      .stall_ex(s_stall_ex), .stall_mem(s_stall_mem), .flush_id(s_flush_id),
      .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic [4:0] wb;
      logic       mr;
      logic       mreq;
      logic       mack;
      logic       br;
      logic [5:0] exp;  // {stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_id}
   } vec_t;

   vec_t vecs[12];

   localparam logic [5:0] c_NONE  = 6'b000000;
   localparam logic [5:0] c_LU    = 6'b111000;
   localparam logic [5:0] c_MW    = 6'b110110;
   localparam logic [5:0] c_FLUSH = 6'b000001;

   function automatic logic [5:0] ctl();
      return {stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_id};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] wb, input logic mr,
                        input logic mreq, input logic mack, input logic br);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      ex_wb_addr = wb; ex_mem_read = mr;
      mem_req = mreq; mem_ack = mack; branch_taken = br;
      #1;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      vecs[0]  = '{5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, c_LU};
      vecs[1]  = '{5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, c_NONE};
      vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, c_NONE};
      vecs[3]  = '{5'd3, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, c_NONE};
      vecs[4]  = '{5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, c_LU};
      vecs[5]  = '{5'd9, 5'd4, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, c_NONE};
      vecs[6]  = '{5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, c_FLUSH};
      vecs[7]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, c_FLUSH};
      vecs[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, c_NONE};
      vecs[9]  = '{5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, c_LU};
      vecs[10] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, c_FLUSH};
      vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_NONE};

      // Reset with every hazard source active: controls must be quiet.
      rst = 1'b1;
      drive(5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("reset_ctl", 64'(ctl()), 64'(c_NONE));
      tick();
      tick();
      chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("reset_flush_cnt", 64'(flush_cnt), 64'd0);
      chk("reset_timeout", 64'(mem_timeout), 64'd0);
      rst = 1'b0;
      idle();
      tick();

      // Single load-use bubble.
      drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_ctl", 64'(ctl()), 64'(c_LU));
      exp_stall++;
      tick();
      drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_next_ctl", 64'(ctl()), 64'(c_NONE));
      chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
      tick();

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].wb,
               vecs[i].mr, vecs[i].mreq, vecs[i].mack, vecs[i].br);
         chk($sformatf("vec%0d_ctl", i), 64'(ctl()), 64'(vecs[i].exp));
         exp_stall += int'(vecs[i].exp[5]);
         exp_flush += int'(vecs[i].exp[0]);
         tick();
      end
      chk("table_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      chk("table_flush_cnt", 64'(flush_cnt), 64'(exp_flush));

      // Memory wait: ack arrives on the fourth cycle.
      for (int i = 0; i < 3; i++) begin
         drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         chk($sformatf("mw_ctl%0d", i), 64'(ctl()), 64'(c_MW));
         exp_stall++;
         tick();
      end
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("mw_ack_ctl", 64'(ctl()), 64'(c_NONE));
      tick();
      idle();
      chk("mw_idle_ctl", 64'(ctl()), 64'(c_NONE));
      chk("mw_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      chk("sat_stall_cnt", 64'(s_stall_cnt), 64'd3);
      tick();

      // Wait with a pending branch: stalls win until the ack.
      for (int i = 0; i < 2; i++) begin
         drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
         chk($sformatf("mwbr_ctl%0d", i), 64'(ctl()), 64'(c_MW));
         exp_stall++;
         tick();
      end
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("mwbr_ack_ctl", 64'(ctl()), 64'(c_FLUSH));
      exp_flush++;
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("mwbr_after_ctl", 64'(ctl()), 64'(c_FLUSH));
      exp_flush++;
      tick();
      idle();
      chk("mwbr_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      chk("mwbr_flush_cnt", 64'(flush_cnt), 64'(exp_flush));
      chk("sat_stall_hold", 64'(s_stall_cnt), 64'd3);
      tick();

      // Reset in the middle of a wait.
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rstwait_ctl", 64'(ctl()), 64'(c_NONE));
      tick();
      rst = 1'b0;
      idle();
      exp_stall = 0;
      exp_flush = 0;
      chk("rstwait_after_ctl", 64'(ctl()), 64'(c_NONE));
      chk("rstwait_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rstwait_flush_cnt", 64'(flush_cnt), 64'd0);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("fresh_wait_ctl", 64'(ctl()), 64'(c_MW));
      exp_stall++;
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("fresh_ack_ctl", 64'(ctl()), 64'(c_NONE));
      tick();
      idle();
      chk("fresh_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      tick();

      // Timeout after four unacknowledged wait cycles.
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_ctl%0d", i), 64'(ctl()), 64'(c_MW));
         chk($sformatf("to_flag%0d", i), 64'(mem_timeout), 64'd0);
         exp_stall++;
         tick();
      end
      chk("to_flag_set", 64'(mem_timeout), 64'd1);
      chk("to_ctl_drop", 64'(ctl()), 64'(c_NONE));
      tick();
      drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("to_lu_ctl", 64'(ctl()), 64'(c_LU));
      exp_stall++;
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("to_br_ctl", 64'(ctl()), 64'(c_FLUSH));
      exp_flush++;
      tick();
      idle();
      tick();
      chk("to_flag_sticky", 64'(mem_timeout), 64'd1);
      chk("to_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      chk("to_flush_cnt", 64'(flush_cnt), 64'(exp_flush));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("to_flag_cleared", 64'(mem_timeout), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
